// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and default pointer width for the Gray-pointer FIFO blocks.
package gray_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_sync2 #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gray_wptr_full.sv
// FIFO write-side pointer with Gray-coded output and registered full flag.
// Define GRAY_WPTR_ALMOST_FULL_EN to add the registered almost_full_o output.
module gray_wptr_full
  import gray_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned AF_TH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   rd_gray_i,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W:0]   wr_gray_o,
  output logic              full_o
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  ,
  output logic              almost_full_o
`endif
);

  localparam int unsigned PW = ADDR_W + 1;

  if (ADDR_W < 2 || AF_TH >= (1 << ADDR_W)) begin : g_param_check
    $error("gray_wptr_full: ADDR_W must be >= 2 and AF_TH below the FIFO depth");
  end

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] rq2_gray;
  logic [ADDR_W:0] full_pattern;
  logic            full_next;

  gray_sync2 #(.W(PW)) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rd_gray_i),
    .q     (rq2_gray)
  );

  // Ack is combinational so the producer learns acceptance in the same cycle.
  assign wr_ack_o  = wr_en_i & ~full_o & reset;
  assign wbin_next = wbin + PW'(wr_ack_o);
  assign gray_next = PW'(bin2gray(32'(wbin_next)));
  assign wr_addr_o = wbin[ADDR_W-1:0];

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign full_pattern = {~rq2_gray[ADDR_W:ADDR_W-1], rq2_gray[ADDR_W-2:0]};
  assign full_next    = (gray_next == full_pattern);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbin      <= '0;
      wr_gray_o <= '0;
      full_o    <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wr_gray_o <= gray_next;
      full_o    <= full_next;
    end
  end

`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic [ADDR_W:0] rq2_bin;
  logic [ADDR_W:0] fill_next;
  logic            almost_full_next;

  assign rq2_bin          = PW'(gray2bin(32'(rq2_gray)));
  assign fill_next        = wbin_next - rq2_bin;
  assign almost_full_next = (fill_next >= PW'((1 << ADDR_W) - AF_TH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      almost_full_o <= 1'b0;
    end else begin
      almost_full_o <= almost_full_next;
    end
  end
`endif

endmodule

// File: tb/tb_gray_wptr_full.sv
// Self-checking bench for gray_wptr_full (ADDR_W=2, AF_TH=1): directed scenarios plus randomized traffic against an occupancy model.
module tb_gray_wptr_full;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int M2     = 2 * DEPTH;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en_i = 1'b0;
  logic [ADDR_W:0]   rd_gray_i = '0;
  logic              wr_ack_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [ADDR_W:0]   wr_gray_o;
  logic              full_o;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic              almost_full_o;
`endif

  int checks = 0;
  int errors = 0;

  gray_wptr_full #(.ADDR_W(ADDR_W), .AF_TH(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_i),
    .rd_gray_i (rd_gray_i),
    .wr_ack_o  (wr_ack_o),
    .wr_addr_o (wr_addr_o),
    .wr_gray_o (wr_gray_o),
    .full_o    (full_o)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    ,
    .almost_full_o (almost_full_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 31; i >= 0; i--) b = b | ((((b >> (i + 1)) ^ (g >> i)) & 1) << i);
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: writes counted in plain integers; reader position seen with two edges of lag.
  int m_wbin   = 0;
  int m_wtotal = 0;
  bit m_full   = 1'b0;
  int h0 = 0, h1 = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wbin = 0; m_wtotal = 0; m_full = 1'b0; h0 = 0; h1 = 0;
    end else begin
      int seen;
      if (wr_en_i && !m_full) begin
        m_wbin   = (m_wbin + 1) % M2;
        m_wtotal = m_wtotal + 1;
      end
      seen   = g2b(h1);
      h1     = h0;
      h0     = int'(rd_gray_i);
      m_full = ((m_wbin - seen + M2) % M2) == DEPTH;
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("mdl_ack",  int'(wr_ack_o),  int'(wr_en_i && !m_full));
      chk("mdl_addr", int'(wr_addr_o), m_wbin % DEPTH);
      chk("mdl_gray", int'(wr_gray_o), b2g(m_wbin));
      chk("mdl_full", int'(full_o),    int'(m_full));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    wr_en_i = 1'b0;
    rd_gray_i = '0;
    repeat (2) edge1();
    reset = 1'b1;
  endtask

  int n;
  int rd_total;

  initial begin
    do_reset();
    // Reset release state
    chk("rst_addr", int'(wr_addr_o), 0);
    chk("rst_gray", int'(wr_gray_o), 0);
    chk("rst_full", int'(full_o), 0);
    chk("rst_ack",  int'(wr_ack_o), 0);

    // Fill with reader parked at 000
    begin
      int exp_g[4] = '{1, 3, 2, 6};
      wr_en_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1 chk("fill_ack", int'(wr_ack_o), 1);
        edge1();
        chk("fill_gray", int'(wr_gray_o), exp_g[i]);
        chk("fill_full", int'(full_o), (i == 3) ? 1 : 0);
      end
    end

    // Write while full is dropped
    #1 chk("drop_ack", int'(wr_ack_o), 0);
    edge1();
    chk("drop_gray", int'(wr_gray_o), 6);
    chk("drop_addr", int'(wr_addr_o), 0);
    wr_en_i = 1'b0;

    // Reader advances: full clears exactly three edges later
    rd_gray_i = 3'b001;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      edge1();
      n++;
      if (!full_o) break;
    end
    if (full_o) chk("unfull_timeout", int'(full_o), 0);
    chk("unfull_lat", n, 3);
    wr_en_i = 1'b1;
    #1 chk("refill_ack", int'(wr_ack_o), 1);
    edge1();
    chk("refill_gray", int'(wr_gray_o), 7);
    wr_en_i = 1'b0;

    // Wrap with the reader tracking the writer
    do_reset();
    wr_en_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      edge1();
      rd_gray_i = 3'(b2g(k % M2));
      chk("wrap_full", int'(full_o), 0);
      if (k == 7) chk("wrap_g7", int'(wr_gray_o), 4);
      if (k == 8) chk("wrap_g8", int'(wr_gray_o), 0);
      if (k == 8) chk("wrap_a8", int'(wr_addr_o), 0);
    end
    wr_en_i = 1'b0;

    // Asynchronous reset mid-operation
    do_reset();
    wr_en_i = 1'b1;
    repeat (3) edge1();
    chk("pre_rst_gray", int'(wr_gray_o), 2);
    #1 reset = 1'b0;
    #1;
    chk("async_addr", int'(wr_addr_o), 0);
    chk("async_gray", int'(wr_gray_o), 0);
    chk("async_full", int'(full_o), 0);
    chk("async_ack",  int'(wr_ack_o), 0);
    wr_en_i = 1'b0;
    edge1();
    reset = 1'b1;
    chk("restart_addr", int'(wr_addr_o), 0);
    wr_en_i = 1'b1;
    edge1();
    chk("restart_gray", int'(wr_gray_o), 1);
    chk("restart_a1",   int'(wr_addr_o), 1);
    wr_en_i = 1'b0;

    // Randomized traffic against the model
    do_reset();
    rd_total = 0;
    for (int c = 0; c < 600; c++) begin
      wr_en_i = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0 && rd_total < m_wtotal) rd_total++;
      rd_gray_i = 3'(b2g(rd_total % M2));
      edge1();
    end
    wr_en_i = 1'b0;
    repeat (2) edge1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
